// File: rtl/dmem_arb_pkg.sv
// Shared constants, request decode and address bit positions for the banked data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_CORES = 4;
    localparam int NUM_BANKS = 4;
    localparam int BANK_LSB  = 2;
    localparam int BANK_W    = 2;
    localparam int WORD_LSB  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } req_t;

    // A simultaneous read and write resolves to a write.
    function automatic req_t req_type(input logic rd, input logic wr);
        if (wr) return WRITE;
        if (rd) return READ;
        return IDLE;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter: one-hot combinational grant, registered rotating priority pointer.
module rr_arbiter4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] ptr
);

    logic [1:0] gnt_idx;
    logic [1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        idx     = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (|req)
            ptr <= gnt_idx + 2'd1;
    end

endmodule

// File: rtl/dmem_bank_arbiter.sv
// Four-bank word-interleaved shared data memory with per-bank round-robin arbitration.
// Optional per-core stall counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_bank_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BANK_DEPTH = 256,
    parameter int BANK_AW    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      core_read_en,
    input  logic [NUM_CORES-1:0]      core_write_en,
    input  logic [NUM_CORES*32-1:0]   core_addr,
    input  logic [NUM_CORES*32-1:0]   core_write_data,
    output logic [NUM_CORES*32-1:0]   core_read_data,
    output logic [NUM_CORES-1:0]      core_read_valid,
    output logic [NUM_CORES-1:0]      core_stall,
    output logic [NUM_CORES*32-1:0]   conflict_count
);

    req_t [NUM_CORES-1:0]                     core_req;
    logic [NUM_CORES-1:0][BANK_W-1:0]         core_bank;
    logic [NUM_CORES-1:0][BANK_AW-1:0]        core_word;
    logic [NUM_CORES-1:0]                     core_act;
    logic [NUM_CORES-1:0]                     core_gnt;
    logic [NUM_CORES-1:0]                     rd_gnt;

    logic [NUM_BANKS-1:0][NUM_CORES-1:0]      bank_req;
    logic [NUM_BANKS-1:0][NUM_CORES-1:0]      bank_gnt;
    logic [NUM_BANKS-1:0][1:0]                rr_ptr;
    logic [NUM_BANKS-1:0]                     bank_we;
    logic [NUM_BANKS-1:0][BANK_AW-1:0]        bank_widx;
    logic [NUM_BANKS-1:0][31:0]               bank_wdata;

    logic [31:0] mem [NUM_BANKS][BANK_DEPTH];

    // Address bits above the word index and the byte offset are don't-care.
    logic unused_ok;
    assign unused_ok = ^{core_addr, rr_ptr};

    // Requests are masked during reset so nothing is granted, stalled or committed.
    always_comb begin
        core_req = '{default: IDLE};
        core_bank = '0;
        core_word = '0;
        core_act  = '0;
        bank_req  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_req[i]  = req_type(core_read_en[i], core_write_en[i]);
            core_act[i]  = !rst && (core_req[i] != IDLE);
            core_bank[i] = core_addr[i*32+BANK_LSB +: BANK_W];
            core_word[i] = core_addr[i*32+WORD_LSB +: BANK_AW];
            for (int b = 0; b < NUM_BANKS; b++)
                bank_req[b][i] = core_act[i] && (core_bank[i] == BANK_W'(b));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter4 u_arb (
            .clk (clk),
            .rst (rst),
            .req (bank_req[b]),
            .gnt (bank_gnt[b]),
            .ptr (rr_ptr[b])
        );
    end

    always_comb begin
        core_gnt   = '0;
        bank_we    = '0;
        bank_widx  = '0;
        bank_wdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            core_gnt = core_gnt | bank_gnt[b];
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bank_gnt[b][i] && core_req[i] == WRITE) begin
                    bank_we[b]    = 1'b1;
                    bank_widx[b]  = core_word[i];
                    bank_wdata[b] = core_write_data[i*32 +: 32];
                end
            end
        end
        rd_gnt = '0;
        for (int i = 0; i < NUM_CORES; i++)
            rd_gnt[i] = core_gnt[i] && core_req[i] == READ;
    end

    assign core_stall = core_act & ~core_gnt;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            if (bank_we[b])
                mem[b][bank_widx[b]] <= bank_wdata[b];
    end

    // One grant per bank per cycle means a read never races a write to its own word.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_read_data  <= '0;
            core_read_valid <= '0;
        end else begin
            core_read_valid <= rd_gnt;
            for (int i = 0; i < NUM_CORES; i++)
                if (rd_gnt[i])
                    core_read_data[i*32 +: 32] <= mem[core_bank[i]][core_word[i]];
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++)
                if (core_stall[i] && conflict_count[i*32 +: 32] != 32'hFFFF_FFFF)
                    conflict_count[i*32 +: 32] <= conflict_count[i*32 +: 32] + 32'd1;
        end
    end
`else
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Table-driven bench for dmem_bank_arbiter with a read-result scoreboard queue.
module tb_dmem_bank_arbiter;

    typedef struct {
        logic [3:0]       rd;
        logic [3:0]       wr;
        logic [3:0][31:0] addr;
        logic [3:0][31:0] wd;
        logic [3:0]       stall;
        logic [3:0]       vld;
        logic [3:0][31:0] rdata;
    } vec_t;

    typedef struct {
        logic [3:0]       vld;
        logic [3:0][31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   core_read_en = '0;
    logic [3:0]   core_write_en = '0;
    logic [127:0] core_addr = '0;
    logic [127:0] core_write_data = '0;
    logic [127:0] core_read_data;
    logic [3:0]   core_read_valid;
    logic [3:0]   core_stall;
    logic [127:0] conflict_count;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tv[$];
    exp_t sb[$];

    dmem_bank_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .core_read_en    (core_read_en),
        .core_write_en   (core_write_en),
        .core_addr       (core_addr),
        .core_write_data (core_write_data),
        .core_read_data  (core_read_data),
        .core_read_valid (core_read_valid),
        .core_stall      (core_stall),
        .conflict_count  (conflict_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr,
                                input logic [127:0] a, input logic [127:0] wdat,
                                input logic [3:0] st, input logic [3:0] vl,
                                input logic [127:0] rdat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wdat;
        v.stall = st; v.vld = vl; v.rdata = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the previous cycle's read results, then drive this cycle and check stalls.
    task automatic apply(input vec_t v, input logic r);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("read_valid", {124'd0, core_read_valid}, {124'd0, e.vld});
            for (int i = 0; i < 4; i++)
                if (e.vld[i])
                    chk($sformatf("read_data[%0d]", i), {96'd0, core_read_data[i*32 +: 32]},
                        {96'd0, e.data[i]});
        end
        rst             = r;
        core_read_en    = v.rd;
        core_write_en   = v.wr;
        core_addr       = v.addr;
        core_write_data = v.wd;
        #1;
        chk("stall", {124'd0, core_stall}, {124'd0, v.stall});
        sb.push_back('{v.vld, v.rdata});
    endtask

    task automatic check_reset_state();
        @(posedge clk);
        #1;
        chk("rst_read_data", core_read_data, 128'd0);
        chk("rst_read_valid", {124'd0, core_read_valid}, 128'd0);
        chk("rst_conflict_count", conflict_count, 128'd0);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        logic [127:0] exp_cc;
        idle = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, '0);

        // Distinct banks: four writes then four reads in parallel.
        tv.push_back(mk(4'h0, 4'hF, {32'h0C, 32'h08, 32'h04, 32'h00},
                        {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b0000, 4'h0, '0));
        tv.push_back(mk(4'hF, 4'h0, {32'h0C, 32'h08, 32'h04, 32'h00}, '0,
                        4'b0000, 4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}));
        // Core 3 seeds 0x10, leaving bank 0's pointer at core 0.
        tv.push_back(mk(4'h0, 4'h8, {32'h10, 32'h0, 32'h0, 32'h0},
                        {32'h3333_0010, 32'h0, 32'h0, 32'h0}, 4'b0000, 4'h0, '0));
        // Full conflict on bank 0.
        tv.push_back(mk(4'hF, 4'h0, {32'h10, 32'h10, 32'h10, 32'h10}, '0,
                        4'b1110, 4'h1, {32'h0, 32'h0, 32'h0, 32'h3333_0010}));
        tv.push_back(mk(4'hE, 4'h0, {32'h10, 32'h10, 32'h10, 32'h0}, '0,
                        4'b1100, 4'h2, {32'h0, 32'h0, 32'h3333_0010, 32'h0}));
        tv.push_back(mk(4'hC, 4'h0, {32'h10, 32'h10, 32'h0, 32'h0}, '0,
                        4'b1000, 4'h4, {32'h0, 32'h3333_0010, 32'h0, 32'h0}));
        tv.push_back(mk(4'h8, 4'h0, {32'h10, 32'h0, 32'h0, 32'h0}, '0,
                        4'b0000, 4'h8, {32'h3333_0010, 32'h0, 32'h0, 32'h0}));
        // Fairness: cores 1 and 2 hammer bank 2, grants alternate 1,2,...
        for (int k = 0; k < 6; k++)
            tv.push_back(mk(4'h0, 4'h6, {32'h0, 32'h28, 32'h18, 32'h0},
                            {32'h0, 32'h2222_0028, 32'h1111_0018, 32'h0},
                            (k % 2 == 0) ? 4'b0100 : 4'b0010, 4'h0, '0));
        tv.push_back(mk(4'h2, 4'h0, {32'h0, 32'h0, 32'h18, 32'h0}, '0,
                        4'b0000, 4'h2, {32'h0, 32'h0, 32'h1111_0018, 32'h0}));
        // Write then read of the same word on the next cycle.
        tv.push_back(mk(4'h0, 4'h8, {32'h40, 32'h0, 32'h0, 32'h0},
                        {32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0}, 4'b0000, 4'h0, '0));
        tv.push_back(mk(4'h1, 4'h0, {32'h0, 32'h0, 32'h0, 32'h40}, '0,
                        4'b0000, 4'h1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}));
        // Both enables: write wins, no read pulse.
        tv.push_back(mk(4'h2, 4'h2, {32'h0, 32'h0, 32'h24, 32'h0},
                        {32'h0, 32'h0, 32'h55, 32'h0}, 4'b0000, 4'h0, '0));
        tv.push_back(mk(4'h4, 4'h0, {32'h0, 32'h24, 32'h0, 32'h0}, '0,
                        4'b0000, 4'h4, {32'h0, 32'h55, 32'h0, 32'h0}));
        // Upper address bits and byte offset are ignored.
        tv.push_back(mk(4'h1, 4'h0, {32'h0, 32'h0, 32'h0, 32'hFFFF_F043}, '0,
                        4'b0000, 4'h1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}));
        tv.push_back(idle);

        apply(idle, 1'b1);
        check_reset_state();

        foreach (tv[n]) apply(tv[n], 1'b0);

`ifdef DMEM_ARB_STATS_EN
        exp_cc = {32'd3, 32'd5, 32'd4, 32'd0};
`else
        exp_cc = '0;
`endif
        chk("conflict_count", conflict_count, exp_cc);

        // Reset during a conflicted cycle with a read and writes pending on bank 1.
        v = mk(4'h1, 4'hE, {32'h24, 32'h24, 32'h24, 32'h24},
               {32'h99, 32'h99, 32'h99, 32'h0}, 4'b0000, 4'h0, '0);
        apply(v, 1'b1);
        check_reset_state();

        // Pointer back at core 0 after reset (it was at core 1 before).
        apply(mk(4'hF, 4'h0, {32'h10, 32'h10, 32'h10, 32'h10}, '0,
                 4'b1110, 4'h1, {32'h0, 32'h0, 32'h0, 32'h3333_0010}), 1'b0);
        // Dropped writes must not have committed.
        apply(mk(4'h4, 4'h0, {32'h0, 32'h24, 32'h0, 32'h0}, '0,
                 4'b0000, 4'h4, {32'h0, 32'h55, 32'h0, 32'h0}), 1'b0);
        apply(idle, 1'b0);
        apply(idle, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
